// File: rtl/relay_tpic_driver_pkg.sv
// Shared definitions for the TPIC relay driver: serializer states, default
// parameters and the latch/gap phase length.
package relay_tpic_driver_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int DEF_WIDTH    = 300;
    localparam int DEF_DIVISOR  = 4;
    localparam int DEF_LED_HALF = 25_000_000;

    // Ticks spent with rck high, and again with rck low before the next LOAD.
    localparam int RCK_TICKS    = 2;

    // Counter width for a count of n states; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relay_tpic_driver_tick_gen.sv
// Tick enable generator: one-cycle pulse every DIVISOR/2 clk cycles, with the
// first pulse taking effect DIVISOR/2 edges after reset release.
module tick_gen
    import relay_tpic_driver_pkg::*;
#(
    parameter int DIVISOR = DEF_DIVISOR
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int HALF = DIVISOR / 2;
    localparam int CW   = cnt_width(HALF);
    localparam logic [CW-1:0] TERM = CW'(HALF - 1);
    // With HALF == 1 every edge is a tick, including the first after reset.
    localparam logic TICK_RST = 1'(HALF == 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Next count and look-ahead tick so the pulse is already registered.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == TERM) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = (cnt_d == TERM);
    end

    // Divider state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= TICK_RST;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/relay_tpic_driver.sv
// Continuous TPIC6x595 refresh: serializes a WIDTH-bit relay image MSB first,
// latches it with rck, enables outputs after the first full frame, and blinks a
// heartbeat LED.
module relay_tpic_driver
    import relay_tpic_driver_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DIVISOR  = DEF_DIVISOR,
    parameter int LED_HALF = DEF_LED_HALF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data,
    output logic             live_led,
    output logic             sclk,
    output logic             sout,
    output logic             rck,
    output logic             en_n
);

    localparam int SHIFT_TICKS = 2 * WIDTH;
    localparam int STEP_W      = cnt_width(SHIFT_TICKS);
    localparam logic [STEP_W-1:0] SHIFT_LAST = STEP_W'(SHIFT_TICKS - 1);
    localparam logic [STEP_W-1:0] RCK_LAST   = STEP_W'(RCK_TICKS - 1);
    localparam int LED_W       = cnt_width(LED_HALF);
    localparam logic [LED_W-1:0] LED_LAST    = LED_W'(LED_HALF - 1);

    logic              tick_s;
    state_e            state_q,  state_d;
    logic [STEP_W-1:0] step_q,   step_d;
    logic [WIDTH-1:0]  shreg_q,  shreg_d;
    logic              sclk_q,   sclk_d;
    logic              sout_q,   sout_d;
    logic              rck_q,    rck_d;
    logic              en_n_q,   en_n_d;
    logic [LED_W-1:0]  led_cnt_q, led_cnt_d;
    logic              led_q,    led_d;

    tick_gen #(
        .DIVISOR (DIVISOR)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick_s)
    );

    // Serializer registers; they only move on tick cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD;
            step_q  <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            sout_q  <= 1'b0;
            rck_q   <= 1'b0;
            en_n_q  <= 1'b1;
        end else if (tick_s) begin
            state_q <= state_d;
            step_q  <= step_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            sout_q  <= sout_d;
            rck_q   <= rck_d;
            en_n_q  <= en_n_d;
        end
    end

    // Phase sequencing: LOAD -> SHIFT (2*WIDTH) -> LATCH (2) -> GAP (2).
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            LOAD: begin
                state_d = SHIFT;
                step_d  = '0;
            end
            SHIFT: begin
                if (step_q == SHIFT_LAST) begin
                    state_d = LATCH;
                    step_d  = '0;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                end
            end
            LATCH: begin
                if (step_q == RCK_LAST) begin
                    state_d = GAP;
                    step_d  = '0;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                end
            end
            GAP: begin
                if (step_q == RCK_LAST) begin
                    state_d = LOAD;
                    step_d  = '0;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                end
            end
            default: begin
                state_d = LOAD;
                step_d  = '0;
            end
        endcase
    end

    // Pin values for the tick being executed; even SHIFT steps raise sclk,
    // odd steps drop it and advance the data so sout never moves while high.
    always_comb begin
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        sout_d  = sout_q;
        rck_d   = rck_q;
        en_n_d  = en_n_q;
        case (state_q)
            LOAD: begin
                shreg_d = data;
                sout_d  = data[WIDTH-1];
                sclk_d  = 1'b0;
                rck_d   = 1'b0;
            end
            SHIFT: begin
                rck_d = 1'b0;
                if (!step_q[0]) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d  = 1'b0;
                    shreg_d = shreg_q << 1;
                    sout_d  = shreg_d[WIDTH-1];
                end
            end
            LATCH: begin
                sclk_d = 1'b0;
                rck_d  = 1'b1;
            end
            GAP: begin
                sclk_d = 1'b0;
                rck_d  = 1'b0;
                en_n_d = 1'b0;
            end
            default: begin
                sclk_d = 1'b0;
                rck_d  = 1'b0;
            end
        endcase
    end

    // Heartbeat next state; runs on every clk, not on ticks.
    always_comb begin
        led_cnt_d = led_cnt_q;
        led_d     = led_q;
        if (led_cnt_q == LED_LAST) begin
            led_cnt_d = '0;
            led_d     = ~led_q;
        end else begin
            led_cnt_d = led_cnt_q + LED_W'(1);
        end
    end

    // Heartbeat registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            led_cnt_q <= led_cnt_d;
            led_q     <= led_d;
        end
    end

    assign live_led = led_q;
    assign sclk     = sclk_q;
    assign sout     = sout_q;
    assign rck      = rck_q;
    assign en_n     = en_n_q;

endmodule

// File: tb/tb_relay_tpic_driver.sv
// Scoreboard bench: stimulus pushes the image each frame must carry, pin
// monitors rebuild frames from sclk/rck and compare timing and content.
module tb_relay_tpic_driver;
    import relay_tpic_driver_pkg::*;

    localparam int WA = 8, DA = 4, LA = 10;
    localparam int WB = 1, DB = 2, LB = 3;
    localparam int WC = DEF_WIDTH, DC = DEF_DIVISOR;
    localparam int FRAME_A = (2 * WA + 5) * (DA / 2);
    localparam int RCKH_A  = RCK_TICKS * (DA / 2);
    localparam int FRAME_B = (2 * WB + 5) * (DB / 2);
    localparam int RCKH_B  = RCK_TICKS * (DB / 2);
    localparam int FRAME_C = (2 * WC + 5) * (DC / 2);
    localparam int NF      = 100;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [WA-1:0] data_a = '0;
    logic [WB-1:0] data_b = 1'b1;
    logic [WC-1:0] data_c = '0;
    logic led_a, sclk_a, sout_a, rck_a, en_n_a;
    logic led_b, sclk_b, sout_b, rck_b, en_n_b;
    logic led_c, sclk_c, sout_c, rck_c, en_n_c;

    int vectors = 0;
    int miscompares = 0;
    int c_rck_cnt = 0;
    logic [WA-1:0] exp_q[$];

    always #10 clk = ~clk;

    relay_tpic_driver #(.WIDTH(WA), .DIVISOR(DA), .LED_HALF(LA)) dut_a (
        .clk(clk), .reset_n(reset_n), .data(data_a), .live_led(led_a),
        .sclk(sclk_a), .sout(sout_a), .rck(rck_a), .en_n(en_n_a));

    relay_tpic_driver #(.WIDTH(WB), .DIVISOR(DB), .LED_HALF(LB)) dut_b (
        .clk(clk), .reset_n(reset_n), .data(data_b), .live_led(led_b),
        .sclk(sclk_b), .sout(sout_b), .rck(rck_b), .en_n(en_n_b));

    relay_tpic_driver dut_c (
        .clk(clk), .reset_n(reset_n), .data(data_c), .live_led(led_c),
        .sclk(sclk_c), .sout(sout_c), .rck(rck_c), .en_n(en_n_c));

    task automatic chk(input string nm, input logic [WC-1:0] act, input logic [WC-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_rises(input int n);
        int seen = 0;
        int cyc = 0;
        logic p = sclk_a;
        while (seen < n && cyc < 4 * FRAME_A) begin
            @(negedge clk);
            cyc++;
            if (sclk_a && !p) seen++;
            p = sclk_a;
        end
        chk("sclk_wait", seen, n);
    endtask

    task automatic wait_rck();
        int cyc = 0;
        logic got = 1'b0;
        logic p = rck_a;
        while (!got && cyc < 4 * FRAME_A) begin
            @(negedge clk);
            cyc++;
            if (rck_a && !p) got = 1'b1;
            p = rck_a;
        end
        chk("rck_wait", got, 1);
    endtask

    // Stimulus: new image mid-SHIFT each frame, one reset mid-SHIFT.
    initial begin : stim
        int k;
        logic [WA-1:0] nd;
        for (int i = 0; i < WC; i++) data_c[i] = 1'($urandom_range(0, 1));
        data_a = 8'hA5;
        exp_q.push_back(8'hA5);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        for (int f = 0; f < NF; f++) begin
            k = (f == 0) ? 3 : $urandom_range(1, 7);
            wait_rises(k);
            #1;
            if (f == 3) begin
                reset_n = 1'b0;
                #1;
                chk("rst_sclk", sclk_a, 0);
                chk("rst_sout", sout_a, 0);
                chk("rst_rck", rck_a, 0);
                chk("rst_en_n", en_n_a, 1);
                chk("rst_led", led_a, 0);
                exp_q.delete();
                nd = 8'($urandom);
                data_a = nd;
                exp_q.push_back(nd);
                repeat (3) @(negedge clk);
                #1 reset_n = 1'b1;
            end else begin
                nd = (f == 0) ? 8'h3C : 8'($urandom);
                data_a = nd;
                exp_q.push_back(nd);
                wait_rck();
            end
        end
        repeat (10) @(negedge clk);
        chk("c_frames_seen", (c_rck_cnt >= 3), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Monitor for the 8-bit instance.
    initial begin : mon_a
        logic [WA-1:0] bits;
        logic [WA-1:0] e;
        int nbits, cyc, last_rck, sclk_hi, rck_hi, led_n;
        logic p_sclk, p_rck, p_sout, latched;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bits = '0; nbits = 0; cyc = 0; last_rck = -1; sclk_hi = 0;
                rck_hi = 0; led_n = 0; p_sclk = 1'b0; p_rck = 1'b0;
                p_sout = 1'b0; latched = 1'b0;
            end else begin
                cyc++;
                led_n++;
                chk("a_led", led_a, (led_n / LA) % 2);
                if (sclk_a && !p_sclk) begin
                    bits = {bits[WA-2:0], sout_a};
                    nbits++;
                    sclk_hi = 1;
                end else if (sclk_a) begin
                    sclk_hi++;
                    chk("a_sout_stable", sout_a, p_sout);
                end else if (p_sclk) begin
                    chk("a_sclk_high", sclk_hi, DA / 2);
                end
                if (rck_a && !p_rck) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : ~bits;
                    chk("a_frame_bits", bits, e);
                    chk("a_frame_nbits", nbits, WA);
                    chk("a_en_n_at_rck", en_n_a, latched ? 1'b0 : 1'b1);
                    if (last_rck >= 0) chk("a_frame_period", cyc - last_rck, FRAME_A);
                    last_rck = cyc;
                    nbits = 0;
                    rck_hi = 1;
                end else if (rck_a) begin
                    rck_hi++;
                end else if (p_rck) begin
                    chk("a_rck_high", rck_hi, RCKH_A);
                    chk("a_en_n_gap", en_n_a, 0);
                    latched = 1'b1;
                end
                p_sclk = sclk_a;
                p_rck = rck_a;
                p_sout = sout_a;
            end
        end
    end

    // Monitor for the 1-bit instance.
    initial begin : mon_b
        int nbits, cyc, last_rck, rck_hi, led_n;
        logic p_sclk, p_rck;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                nbits = 0; cyc = 0; last_rck = -1; rck_hi = 0; led_n = 0;
                p_sclk = 1'b0; p_rck = 1'b0;
            end else begin
                cyc++;
                led_n++;
                chk("b_led", led_b, (led_n / LB) % 2);
                if (sclk_b && !p_sclk) begin
                    nbits++;
                    chk("b_sout_at_sclk", sout_b, data_b);
                end
                if (rck_b && !p_rck) begin
                    chk("b_frame_nbits", nbits, WB);
                    if (last_rck >= 0) chk("b_frame_period", cyc - last_rck, FRAME_B);
                    last_rck = cyc;
                    nbits = 0;
                    rck_hi = 1;
                end else if (rck_b) begin
                    rck_hi++;
                end else if (p_rck) begin
                    chk("b_rck_high", rck_hi, RCKH_B);
                end
                p_sclk = sclk_b;
                p_rck = rck_b;
            end
        end
    end

    // Monitor for the default-size instance.
    initial begin : mon_c
        logic [WC-1:0] bits;
        int nbits, cyc, last_rck;
        logic p_sclk, p_rck;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bits = '0; nbits = 0; cyc = 0; last_rck = -1;
                p_sclk = 1'b0; p_rck = 1'b0; c_rck_cnt = 0;
            end else begin
                cyc++;
                if (sclk_c && !p_sclk) begin
                    bits = {bits[WC-2:0], sout_c};
                    nbits++;
                end
                if (rck_c && !p_rck) begin
                    c_rck_cnt++;
                    chk("c_frame_nbits", nbits, WC);
                    chk("c_frame_bits", bits, data_c);
                    if (last_rck >= 0) chk("c_frame_period", cyc - last_rck, FRAME_C);
                    last_rck = cyc;
                    nbits = 0;
                end
                p_sclk = sclk_c;
                p_rck = rck_c;
            end
        end
    end

    // Run-time bound.
    initial begin : watchdog
        #(20000 * 20);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
